multibank_epoch_scheduler: RTL and testbench

//  Successor of the two-bank measurement scheduler. Rotates C_N_BANKS counter RAM banks across fixed-length epochs:

---
 rtl/measure_sched_pkg.sv | 30 +++
 rtl/sched_req_fifo.sv | 50 +++++
 rtl/multibank_epoch_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_multibank_epoch_scheduler.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/measure_sched_pkg.sv
// Shared definitions for the multibank epoch scheduler:
// FSM state encoding, a constant clog2 helper and the default bank-index width.
package measure_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_UPD   = 3'd4,
    ST_WB    = 3'd5
  } sched_state_t;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int C_N_BANKS_DEFAULT = 4;
  localparam int C_BANK_IDX_W      = clog2(C_N_BANKS_DEFAULT);

endpackage

// File: rtl/sched_req_fifo.sv
// First-word-fall-through request FIFO holding {length, id} records.
// A push while full is accepted only when a pop happens in the same cycle.
module sched_req_fifo
  import measure_sched_pkg::*;
#(
  parameter int C_WIDTH      = 28,
  parameter int C_DEPTH_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [C_WIDTH-1:0] din,
  input  logic               pop,
  output logic [C_WIDTH-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 2 ** C_DEPTH_BITS;

  logic [C_WIDTH-1:0]  mem [DEPTH];
  logic [C_DEPTH_BITS:0] wr_ptr;
  logic [C_DEPTH_BITS:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[C_DEPTH_BITS] != rd_ptr[C_DEPTH_BITS]) &&
                   (wr_ptr[C_DEPTH_BITS-1:0] == rd_ptr[C_DEPTH_BITS-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[C_DEPTH_BITS-1:0]];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[C_DEPTH_BITS-1:0]] <= din;
  end

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/multibank_epoch_scheduler.sv
// Multibank epoch scheduler: rotates counter banks across fixed-length epochs,
// runs one read-modify-write per packet record through the external calc stage,
// and flags the previous epoch's bank readable to the collector.
// Optional build macro: SCHED_DROP_CNT_EN adds out_drop_cnt (saturating count of dropped pushes).
// C_RAM_LAT must be at least 2 (RD is always followed by at least one WAIT cycle).
//
// state | meaning
// IDLE  | waiting for a record, enable and the write window
// RD    | read enable to the locked bank, address = locked id
// WAIT  | read enable held until RAM data is valid
// ISSUE | one-cycle out_next_valid to calc, record popped
// UPD   | waiting for calc result with matching id, timeout running
// WB    | one-cycle write of the calc result into the locked bank
module multibank_epoch_scheduler
  import measure_sched_pkg::*;
#(
  parameter int C_LENGTH_WIDTH    = 16,
  parameter int C_ID_WIDTH        = 12,
  parameter int C_COUNTER_WIDTH   = 20,
  parameter int C_N_BANKS         = 4,
  parameter int C_FIFO_DEPTH_BITS = 4,
  parameter int C_MIN_PERIOD      = 500,
  parameter int C_GUARD           = 10,
  parameter int C_RAM_LAT         = 2,
  parameter int C_UPD_TIMEOUT     = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_enable,
  input  logic [31:0]                          in_time_p,
  input  logic                                 in_sdn_valid,
  input  logic [C_LENGTH_WIDTH-1:0]            in_sdn_length,
  input  logic [C_ID_WIDTH-1:0]                in_sdn_id,
  output logic                                 out_sdn_full,
  output logic                                 out_next_valid,
  output logic [C_COUNTER_WIDTH-1:0]           out_next_counter,
  output logic [C_LENGTH_WIDTH-1:0]            out_next_length,
  output logic [C_ID_WIDTH-1:0]                out_next_id,
  output logic [clog2(C_N_BANKS)-1:0]          out_next_bank,
  input  logic                                 in_update_c_valid,
  input  logic [C_COUNTER_WIDTH-1:0]           in_update_counter_data,
  input  logic [C_ID_WIDTH-1:0]                in_update_id_data,
  output logic [C_N_BANKS-1:0]                 out_ready_read,
  output logic [clog2(C_N_BANKS)-1:0]          out_epoch_idx,
  output logic [C_N_BANKS-1:0]                 out_ram_en,
  output logic [C_N_BANKS-1:0]                 out_ram_we,
  output logic [C_ID_WIDTH-1:0]                out_ram_addr,
  output logic [C_COUNTER_WIDTH-1:0]           out_ram_din,
  input  logic [C_N_BANKS*C_COUNTER_WIDTH-1:0] in_ram_dout,
  output logic                                 out_err_timeout
`ifdef SCHED_DROP_CNT_EN
  ,
  output logic [31:0]                          out_drop_cnt
`endif
);

  localparam int BW    = clog2(C_N_BANKS);
  localparam int LAT_W = clog2(C_RAM_LAT + 1);
  localparam int TMO_W = clog2(C_UPD_TIMEOUT + 1);
  localparam int REC_W = C_LENGTH_WIDTH + C_ID_WIDTH;

  sched_state_t                state;
  sched_state_t                state_nxt;
  logic [31:0]                 time_cnt;
  logic [31:0]                 period;
  logic [BW-1:0]               epoch_idx;
  logic [BW-1:0]               rd_bank;
  logic                        in_window;
  logic                        start_ok;
  logic                        upd_hit;
  logic                        lock;
  logic                        fifo_pop;
  logic                        fifo_empty;
  logic [REC_W-1:0]            fifo_dout;
  logic [BW-1:0]               lk_bank;
  logic [C_ID_WIDTH-1:0]       lk_id;
  logic [C_LENGTH_WIDTH-1:0]   lk_len;
  logic [LAT_W-1:0]            lat_cnt;
  logic [TMO_W-1:0]            tmo_cnt;
  logic [C_COUNTER_WIDTH-1:0]  upd_data;
  logic [C_COUNTER_WIDTH-1:0]  dout_bank [C_N_BANKS];

  for (genvar b = 0; b < C_N_BANKS; b++) begin : g_dout
    assign dout_bank[b] = in_ram_dout[b*C_COUNTER_WIDTH +: C_COUNTER_WIDTH];
  end

  sched_req_fifo #(
    .C_WIDTH      (REC_W),
    .C_DEPTH_BITS (C_FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_sdn_valid),
    .din   ({in_sdn_length, in_sdn_id}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (out_sdn_full),
    .empty (fifo_empty)
  );

  assign in_window     = (time_cnt >= 32'(C_GUARD)) && (time_cnt < period - 32'(C_GUARD));
  assign start_ok      = !fifo_empty && in_enable && in_window;
  assign upd_hit       = in_update_c_valid && (in_update_id_data == lk_id);
  assign rd_bank       = epoch_idx - BW'(1);
  assign out_epoch_idx = epoch_idx;

  // Epoch timer; the next period is sampled and clamped at each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_cnt  <= '0;
      epoch_idx <= '0;
      period    <= 32'(C_MIN_PERIOD);
    end else if (time_cnt == period - 32'd1) begin
      time_cnt  <= '0;
      epoch_idx <= epoch_idx + BW'(1);
      period    <= (in_time_p < 32'(C_MIN_PERIOD)) ? 32'(C_MIN_PERIOD) : in_time_p;
    end else begin
      time_cnt  <= time_cnt + 32'd1;
    end
  end

  // Readable-bank flag for the collector, cleared during the guard bands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_ready_read <= '0;
    else     out_ready_read <= in_window ? (C_N_BANKS'(1) << rd_bank) : '0;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Locked record, RAM latency / update timeout down-counters and captured calc result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_bank  <= '0;
      lk_id    <= '0;
      lk_len   <= '0;
      lat_cnt  <= '0;
      tmo_cnt  <= '0;
      upd_data <= '0;
    end else begin
      if (lock) begin
        lk_bank <= epoch_idx;
        lk_id   <= fifo_dout[C_ID_WIDTH-1:0];
        lk_len  <= fifo_dout[REC_W-1:C_ID_WIDTH];
      end
      if (state == ST_RD)
        lat_cnt <= LAT_W'(C_RAM_LAT - 2);
      else if (state == ST_WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - LAT_W'(1);
      if (state == ST_ISSUE)
        tmo_cnt <= TMO_W'(C_UPD_TIMEOUT);
      else if (state == ST_UPD)
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      if (state == ST_UPD && upd_hit)
        upd_data <= in_update_counter_data;
    end
  end

  // Next-state and output decode; the locked bank is used even after an epoch wrap.
  always_comb begin
    state_nxt        = state;
    lock             = 1'b0;
    fifo_pop         = 1'b0;
    out_next_valid   = 1'b0;
    out_next_counter = '0;
    out_next_length  = '0;
    out_next_id      = '0;
    out_next_bank    = '0;
    out_ram_en       = '0;
    out_ram_we       = '0;
    out_ram_addr     = '0;
    out_ram_din      = '0;
    out_err_timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          lock      = 1'b1;
          state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        out_ram_en[lk_bank] = 1'b1;
        out_ram_addr        = lk_id;
        state_nxt           = ST_WAIT;
      end
      ST_WAIT: begin
        out_ram_en[lk_bank] = 1'b1;
        out_ram_addr        = lk_id;
        if (lat_cnt == '0) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        out_next_valid   = 1'b1;
        out_next_counter = dout_bank[lk_bank];
        out_next_length  = lk_len;
        out_next_id      = lk_id;
        out_next_bank    = lk_bank;
        fifo_pop         = 1'b1;
        state_nxt        = ST_UPD;
      end
      ST_UPD: begin
        if (upd_hit) begin
          state_nxt = ST_WB;
        end else if (tmo_cnt == TMO_W'(1)) begin
          out_err_timeout = 1'b1;
          state_nxt       = ST_IDLE;
        end
      end
      ST_WB: begin
        out_ram_en[lk_bank] = 1'b1;
        out_ram_we[lk_bank] = 1'b1;
        out_ram_addr        = lk_id;
        out_ram_din         = upd_data;
        if (start_ok) begin
          lock      = 1'b1;
          state_nxt = ST_RD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef SCHED_DROP_CNT_EN
  // Saturating count of records lost because the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_drop_cnt <= '0;
    else if (in_sdn_valid && out_sdn_full && !fifo_pop && out_drop_cnt != 32'hFFFF_FFFF)
      out_drop_cnt <= out_drop_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multibank_epoch_scheduler.sv
// Directed bench for multibank_epoch_scheduler with a 2-cycle-latency RAM model.
// Unwritten RAM words read as addr + 2 + 100*bank; reads without enable return 20'hBAD00.
module tb_multibank_epoch_scheduler;

  logic        clk;
  logic        rst;
  logic        in_enable;
  logic [31:0] in_time_p;
  logic        in_sdn_valid;
  logic [15:0] in_sdn_length;
  logic [11:0] in_sdn_id;
  logic        out_sdn_full;
  logic        out_next_valid;
  logic [19:0] out_next_counter;
  logic [15:0] out_next_length;
  logic [11:0] out_next_id;
  logic [1:0]  out_next_bank;
  logic        in_update_c_valid;
  logic [19:0] in_update_counter_data;
  logic [11:0] in_update_id_data;
  logic [3:0]  out_ready_read;
  logic [1:0]  out_epoch_idx;
  logic [3:0]  out_ram_en;
  logic [3:0]  out_ram_we;
  logic [11:0] out_ram_addr;
  logic [19:0] out_ram_din;
  logic [79:0] in_ram_dout;
  logic        out_err_timeout;
`ifdef SCHED_DROP_CNT_EN
  logic [31:0] out_drop_cnt;
`endif

  int n_cmp;
  int n_bad;
  int cyc;

  logic [19:0] mem   [4][4096];
  bit          wflag [4][4096];
  logic [19:0] p1    [4];
  logic [19:0] p2    [4];

  multibank_epoch_scheduler dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_enable              (in_enable),
    .in_time_p              (in_time_p),
    .in_sdn_valid           (in_sdn_valid),
    .in_sdn_length          (in_sdn_length),
    .in_sdn_id              (in_sdn_id),
    .out_sdn_full           (out_sdn_full),
    .out_next_valid         (out_next_valid),
    .out_next_counter       (out_next_counter),
    .out_next_length        (out_next_length),
    .out_next_id            (out_next_id),
    .out_next_bank          (out_next_bank),
    .in_update_c_valid      (in_update_c_valid),
    .in_update_counter_data (in_update_counter_data),
    .in_update_id_data      (in_update_id_data),
    .out_ready_read         (out_ready_read),
    .out_epoch_idx          (out_epoch_idx),
    .out_ram_en             (out_ram_en),
    .out_ram_we             (out_ram_we),
    .out_ram_addr           (out_ram_addr),
    .out_ram_din            (out_ram_din),
    .in_ram_dout            (in_ram_dout),
    .out_err_timeout        (out_err_timeout)
`ifdef SCHED_DROP_CNT_EN
    ,
    .out_drop_cnt           (out_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT time_cnt while in epoch 0.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // RAM banks with two-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (out_ram_en[b] && out_ram_we[b]) begin
        mem[b][out_ram_addr]   <= out_ram_din;
        wflag[b][out_ram_addr] <= 1'b1;
      end
      if (out_ram_en[b])
        p1[b] <= wflag[b][out_ram_addr] ? mem[b][out_ram_addr] : 20'(out_ram_addr + 2 + b * 100);
      else
        p1[b] <= 20'hBAD00;
      p2[b] <= p1[b];
    end
  end
  assign in_ram_dout = {p2[3], p2[2], p2[1], p2[0]};

  task automatic goto(input int a);
    while (cyc < a) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_enable = 1'b1;
    in_time_p = 32'd500;
    in_sdn_valid = 1'b0;
    in_sdn_length = '0;
    in_sdn_id = '0;
    in_update_c_valid = 1'b0;
    in_update_counter_data = '0;
    in_update_id_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_ram_en, out_ram_we, out_next_valid, out_err_timeout, out_sdn_full} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got en=%b we=%b nv=%b err=%b full=%b want all 0",
               out_ram_en, out_ram_we, out_next_valid, out_err_timeout, out_sdn_full);
    end
    n_cmp++;
    if (out_ready_read !== 4'b0 || out_epoch_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_epoch: got rr=%b idx=%0d want 0/0", out_ready_read, out_epoch_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_rmw;
    goto(5);
    n_cmp++;
    if (out_ready_read !== 4'b0000) begin
      n_bad++; $display("FAIL rr_guard_start: got %b want 0000", out_ready_read);
    end
    goto(20);
    n_cmp++;
    if (out_ready_read !== 4'b1000) begin
      n_bad++; $display("FAIL rr_epoch0: got %b want 1000", out_ready_read);
    end
    in_sdn_valid = 1'b1; in_sdn_id = 12'd5; in_sdn_length = 16'd64;
    goto(21);
    in_sdn_valid = 1'b0;
    goto(22);
    n_cmp++;
    if (out_ram_en !== 4'b0001 || out_ram_addr !== 12'd5 || out_ram_we !== 4'b0) begin
      n_bad++; $display("FAIL basic_rd: got en=%b addr=%0d we=%b want 0001/5/0000", out_ram_en, out_ram_addr, out_ram_we);
    end
    goto(24);
    n_cmp++;
    if (out_next_valid !== 1'b1 || out_next_counter !== 20'd7 || out_next_length !== 16'd64 ||
        out_next_id !== 12'd5 || out_next_bank !== 2'd0) begin
      n_bad++;
      $display("FAIL basic_issue: got v=%b cnt=%0d len=%0d id=%0d bank=%0d want 1/7/64/5/0",
               out_next_valid, out_next_counter, out_next_length, out_next_id, out_next_bank);
    end
    goto(25);
    in_update_c_valid = 1'b1; in_update_id_data = 12'd6; in_update_counter_data = 20'd99;
    n_cmp++;
    if (out_next_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_pulse_len: got nv=%b want 0", out_next_valid);
    end
    goto(26);
    in_update_id_data = 12'd5; in_update_counter_data = 20'd71;
    n_cmp++;
    if (out_ram_we !== 4'b0000) begin
      n_bad++; $display("FAIL basic_id_mismatch: got we=%b want 0000", out_ram_we);
    end
    goto(27);
    in_update_c_valid = 1'b0;
    n_cmp++;
    if (out_ram_we !== 4'b0001 || out_ram_en !== 4'b0001 || out_ram_addr !== 12'd5 || out_ram_din !== 20'd71) begin
      n_bad++;
      $display("FAIL basic_wb: got we=%b en=%b addr=%0d din=%0d want 0001/0001/5/71",
               out_ram_we, out_ram_en, out_ram_addr, out_ram_din);
    end
    goto(28);
    n_cmp++;
    if (out_ram_en !== 4'b0000 || out_ram_we !== 4'b0000) begin
      n_bad++; $display("FAIL basic_idle: got en=%b we=%b want 0000/0000", out_ram_en, out_ram_we);
    end
  endtask

  // Also requests a 100-cycle period, which must be clamped to 500 for epoch 1.
  task automatic test_guard_hold;
    goto(100);
    in_time_p = 32'd100;
    goto(495);
    in_sdn_valid = 1'b1; in_sdn_id = 12'd9; in_sdn_length = 16'd33;
    goto(496);
    in_sdn_valid = 1'b0;
    goto(497);
    n_cmp++;
    if (out_ram_en !== 4'b0000 || out_ready_read !== 4'b0000) begin
      n_bad++; $display("FAIL guard_hold: got en=%b rr=%b want 0000/0000", out_ram_en, out_ready_read);
    end
    goto(500);
    n_cmp++;
    if (out_epoch_idx !== 2'd1) begin
      n_bad++; $display("FAIL wrap_500: got idx=%0d want 1", out_epoch_idx);
    end
    goto(510);
    n_cmp++;
    if (out_ram_en !== 4'b0000) begin
      n_bad++; $display("FAIL guard_tc10: got en=%b want 0000", out_ram_en);
    end
    goto(511);
    n_cmp++;
    if (out_ram_en !== 4'b0010 || out_ram_addr !== 12'd9) begin
      n_bad++; $display("FAIL guard_rd: got en=%b addr=%0d want 0010/9", out_ram_en, out_ram_addr);
    end
    goto(513);
    n_cmp++;
    if (out_next_valid !== 1'b1 || out_next_counter !== 20'd111 || out_next_bank !== 2'd1 || out_next_length !== 16'd33) begin
      n_bad++;
      $display("FAIL guard_issue: got v=%b cnt=%0d bank=%0d len=%0d want 1/111/1/33",
               out_next_valid, out_next_counter, out_next_bank, out_next_length);
    end
    goto(514);
    in_update_c_valid = 1'b1; in_update_id_data = 12'd9; in_update_counter_data = 20'd112;
    goto(515);
    in_update_c_valid = 1'b0;
    n_cmp++;
    if (out_ram_we !== 4'b0010 || out_ram_din !== 20'd112) begin
      n_bad++; $display("FAIL guard_wb: got we=%b din=%0d want 0010/112", out_ram_we, out_ram_din);
    end
    goto(520);
    n_cmp++;
    if (out_ready_read !== 4'b0001) begin
      n_bad++; $display("FAIL rr_epoch1: got %b want 0001", out_ready_read);
    end
  endtask

  task automatic test_period_clamp;
    goto(600);
    in_time_p = 32'd800;
    goto(999);
    n_cmp++;
    if (out_epoch_idx !== 2'd1) begin
      n_bad++; $display("FAIL clamp_999: got idx=%0d want 1", out_epoch_idx);
    end
    goto(1000);
    n_cmp++;
    if (out_epoch_idx !== 2'd2) begin
      n_bad++; $display("FAIL clamp_1000: got idx=%0d want 2", out_epoch_idx);
    end
    goto(1200);
    in_time_p = 32'd500;
    goto(1799);
    n_cmp++;
    if (out_epoch_idx !== 2'd2) begin
      n_bad++; $display("FAIL p800_1799: got idx=%0d want 2", out_epoch_idx);
    end
    goto(1800);
    n_cmp++;
    if (out_epoch_idx !== 2'd3) begin
      n_bad++; $display("FAIL p800_1800: got idx=%0d want 3", out_epoch_idx);
    end
    goto(2300);
    n_cmp++;
    if (out_epoch_idx !== 2'd0) begin
      n_bad++; $display("FAIL idx_modN: got idx=%0d want 0", out_epoch_idx);
    end
  endtask

  task automatic test_wrap_inflight;
    goto(2786);
    in_sdn_valid = 1'b1; in_sdn_id = 12'd12; in_sdn_length = 16'd1;
    goto(2787);
    in_sdn_valid = 1'b0;
    goto(2788);
    n_cmp++;
    if (out_ram_en !== 4'b0001 || out_ram_addr !== 12'd12) begin
      n_bad++; $display("FAIL inflight_rd: got en=%b addr=%0d want 0001/12", out_ram_en, out_ram_addr);
    end
    goto(2790);
    n_cmp++;
    if (out_next_valid !== 1'b1 || out_next_counter !== 20'd14 || out_next_bank !== 2'd0) begin
      n_bad++; $display("FAIL inflight_issue: got v=%b cnt=%0d bank=%0d want 1/14/0", out_next_valid, out_next_counter, out_next_bank);
    end
    goto(2795);
    n_cmp++;
    if (out_ready_read !== 4'b0000) begin
      n_bad++; $display("FAIL rr_guard_end: got %b want 0000", out_ready_read);
    end
    goto(2805);
    in_update_c_valid = 1'b1; in_update_id_data = 12'd12; in_update_counter_data = 20'd15;
    goto(2806);
    in_update_c_valid = 1'b0;
    n_cmp++;
    if (out_ram_we !== 4'b0001 || out_ram_din !== 20'd15 || out_ram_addr !== 12'd12 || out_epoch_idx !== 2'd1) begin
      n_bad++;
      $display("FAIL inflight_wb: got we=%b din=%0d addr=%0d idx=%0d want 0001/15/12/1",
               out_ram_we, out_ram_din, out_ram_addr, out_epoch_idx);
    end
  endtask

  task automatic test_timeout;
    int we_seen;
    int err_early;
    goto(2900);
    in_sdn_valid = 1'b1; in_sdn_id = 12'd20; in_sdn_length = 16'd2;
    goto(2901);
    in_sdn_id = 12'd21; in_sdn_length = 16'd3;
    goto(2902);
    in_sdn_valid = 1'b0;
    goto(2904);
    n_cmp++;
    if (out_next_valid !== 1'b1 || out_next_id !== 12'd20 || out_next_counter !== 20'd122) begin
      n_bad++; $display("FAIL tmo_issue: got v=%b id=%0d cnt=%0d want 1/20/122", out_next_valid, out_next_id, out_next_counter);
    end
    we_seen = 0;
    err_early = 0;
    for (int a = 2905; a <= 2967; a++) begin
      goto(a);
      if (out_ram_we !== 4'b0) we_seen++;
      if (out_err_timeout !== 1'b0) err_early++;
    end
    n_cmp++;
    if (err_early != 0) begin
      n_bad++; $display("FAIL tmo_early: got %0d early pulses want 0", err_early);
    end
    goto(2968);
    n_cmp++;
    if (out_err_timeout !== 1'b1 || out_ram_we !== 4'b0) begin
      n_bad++; $display("FAIL tmo_pulse: got err=%b we=%b want 1/0000", out_err_timeout, out_ram_we);
    end
    goto(2969);
    n_cmp++;
    if (out_err_timeout !== 1'b0 || we_seen != 0) begin
      n_bad++; $display("FAIL tmo_after: got err=%b we_cycles=%0d want 0/0", out_err_timeout, we_seen);
    end
    goto(2972);
    n_cmp++;
    if (out_next_valid !== 1'b1 || out_next_id !== 12'd21 || out_next_counter !== 20'd123) begin
      n_bad++; $display("FAIL tmo_next_rec: got v=%b id=%0d cnt=%0d want 1/21/123", out_next_valid, out_next_id, out_next_counter);
    end
    goto(2973);
    in_update_c_valid = 1'b1; in_update_id_data = 12'd21; in_update_counter_data = 20'd124;
    goto(2974);
    in_update_c_valid = 1'b0;
    n_cmp++;
    if (out_ram_we !== 4'b0010 || out_ram_din !== 20'd124) begin
      n_bad++; $display("FAIL tmo_next_wb: got we=%b din=%0d want 0010/124", out_ram_we, out_ram_din);
    end
  endtask

  task automatic test_back_to_back;
    goto(2990);
    in_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      goto(3000 + i);
      in_sdn_valid = 1'b1; in_sdn_id = 12'(100 + i); in_sdn_length = 16'(i);
      if (i == 15) begin
        n_cmp++;
        if (out_sdn_full !== 1'b0) begin
          n_bad++; $display("FAIL full_15: got %b want 0", out_sdn_full);
        end
      end
      if (i == 16) begin
        n_cmp++;
        if (out_sdn_full !== 1'b1) begin
          n_bad++; $display("FAIL full_16: got %b want 1", out_sdn_full);
        end
      end
    end
    goto(3020);
    in_sdn_valid = 1'b0;
    n_cmp++;
    if (out_ram_en !== 4'b0000 || out_sdn_full !== 1'b1) begin
      n_bad++; $display("FAIL hold_disabled: got en=%b full=%b want 0000/1", out_ram_en, out_sdn_full);
    end
`ifdef SCHED_DROP_CNT_EN
    n_cmp++;
    if (out_drop_cnt !== 32'd4) begin
      n_bad++; $display("FAIL drop_cnt: got %0d want 4", out_drop_cnt);
    end
`endif
    in_enable = 1'b1;
    goto(3021);
    n_cmp++;
    if (out_ram_en !== 4'b0010 || out_ram_addr !== 12'd100) begin
      n_bad++; $display("FAIL b2b_rd: got en=%b addr=%0d want 0010/100", out_ram_en, out_ram_addr);
    end
    goto(3023);
    n_cmp++;
    if (out_next_valid !== 1'b1 || out_next_id !== 12'd100 || out_next_counter !== 20'd202 || out_sdn_full !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_issue: got v=%b id=%0d cnt=%0d full=%b want 1/100/202/1",
               out_next_valid, out_next_id, out_next_counter, out_sdn_full);
    end
  endtask

  task automatic test_rst_mid_rmw;
    goto(3024);
    n_cmp++;
    if (out_sdn_full !== 1'b0 || out_ready_read !== 4'b0001) begin
      n_bad++; $display("FAIL pre_rst: got full=%b rr=%b want 0/0001", out_sdn_full, out_ready_read);
    end
    in_update_c_valid = 1'b1; in_update_id_data = 12'd100; in_update_counter_data = 20'd5;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_ram_en, out_ram_we, out_next_valid, out_err_timeout, out_sdn_full} !== 11'd0 ||
        out_ready_read !== 4'b0 || out_epoch_idx !== 2'd0 || out_ram_addr !== 12'd0) begin
      n_bad++;
      $display("FAIL rst_mid_rmw: got en=%b we=%b nv=%b err=%b full=%b rr=%b idx=%0d addr=%0d want all 0",
               out_ram_en, out_ram_we, out_next_valid, out_err_timeout, out_sdn_full,
               out_ready_read, out_epoch_idx, out_ram_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (out_ram_we !== 4'b0 || out_ram_en !== 4'b0) begin
      n_bad++; $display("FAIL rst_hold: got en=%b we=%b want 0000/0000", out_ram_en, out_ram_we);
    end
    in_update_c_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_rmw();
    test_guard_hold();
    test_period_clamp();
    test_wrap_inflight();
    test_timeout();
    test_back_to_back();
    test_rst_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
